// File: rtl/qar_mem_responder.sv
// Single-port word memory answering a simple req/ready core bus with a fixed response latency.
// Accesses that are misaligned or fall outside the window are answered with mem_err.
module qar_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = 16;
    localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               lat_we_q, lat_we_d;
    logic [31:0]        lat_addr_q, lat_addr_d;
    logic [31:0]        lat_wdata_q, lat_wdata_d;
    logic               mem_ready_q, mem_ready_d;
    logic               mem_err_q, mem_err_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic [CNT_W-1:0]   rd_count_q, rd_count_d;
    logic [CNT_W-1:0]   wr_count_q, wr_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic [31:0]        mem_q [DEPTH_WORDS] = '{default: 32'h0};

    logic               eff_we_c;
    logic [31:0]        eff_addr_c;
    logic [31:0]        offset_c;
    logic               addr_ok_c;
    logic [IDX_W-1:0]   idx_c;
    logic               enter_resp_c;
    logic               mem_wr_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Decode the live request in IDLE, the latched one afterwards.
    always_comb begin
        eff_we_c   = (state_q == S_IDLE) ? mem_we   : lat_we_q;
        eff_addr_c = (state_q == S_IDLE) ? mem_addr : lat_addr_q;
        offset_c   = eff_addr_c - BASE_ADDR;
        addr_ok_c  = (offset_c[1:0] == 2'b00) && (eff_addr_c >= BASE_ADDR)
                     && (offset_c[31:2] < 30'(DEPTH_WORDS));
        idx_c      = offset_c[IDX_W+1:2];
    end

    // Next state, latches, registered response and commit decisions.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        mem_ready_d  = 1'b0;
        mem_err_d    = 1'b0;
        mem_rdata_d  = 32'h0;
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        err_count_d  = err_count_q;
        enter_resp_c = 1'b0;
        mem_wr_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    lat_we_d    = mem_we;
                    lat_addr_d  = mem_addr;
                    lat_wdata_d = mem_wdata;
                    if (LATENCY > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = LAT_M1;
                    end else begin
                        state_d      = S_RESP;
                        enter_resp_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Commit on the edge leaving RESP so a reset during RESP still abandons it.
                state_d = S_IDLE;
                if (mem_err_q) begin
                    err_count_d = sat_inc(err_count_q);
                end else if (lat_we_q) begin
                    mem_wr_c   = 1'b1;
                    wr_count_d = sat_inc(wr_count_q);
                end else begin
                    rd_count_d = sat_inc(rd_count_q);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp_c) begin
            mem_ready_d = 1'b1;
            mem_err_d   = ~addr_ok_c;
            mem_rdata_d = (addr_ok_c && !eff_we_c) ? mem_q[idx_c] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 32'h0;
            lat_wdata_q <= 32'h0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= 32'h0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Array has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_wr_c && !rst) begin
            mem_q[idx_c] <= lat_wdata_q;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_qar_mem_responder.sv
// Randomized self-checking bench: a LATENCY=2 instance driven transaction by transaction and a
// LATENCY=0 instance with mem_req held high, both against an array/counter reference model.
module tb_qar_mem_responder;

    localparam int unsigned DEPTH_A = 256;
    localparam int unsigned LAT_A   = 2;
    localparam logic [31:0] BASE_A  = 32'h0000_0000;
    localparam int unsigned DEPTH_B = 16;
    localparam logic [31:0] BASE_B  = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_we, a_ready, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [15:0] a_rdc, a_wrc, a_erc;
    logic        b_req, b_we, b_ready, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [15:0] b_rdc, b_wrc, b_erc;

    qar_mem_responder #(.DEPTH_WORDS(DEPTH_A), .BASE_ADDR(BASE_A), .LATENCY(LAT_A)) u_a (
        .clk(clk), .rst(rst), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready), .mem_err(a_err),
        .rd_count(a_rdc), .wr_count(a_wrc), .err_count(a_erc));

    qar_mem_responder #(.DEPTH_WORDS(DEPTH_B), .BASE_ADDR(BASE_B), .LATENCY(0)) u_b (
        .clk(clk), .rst(rst), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_err(b_err),
        .rd_count(b_rdc), .wr_count(b_wrc), .err_count(b_erc));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl_a [DEPTH_A];
    logic [31:0] mdl_b [DEPTH_B];
    int unsigned ma_rd = 0, ma_wr = 0, ma_er = 0;
    int unsigned mb_rd = 0, mb_wr = 0, mb_er = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a, input logic [31:0] base,
                                      input int unsigned depth);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(base);
        return ((a % 32'd4) == 32'd0) && (la >= lb) && ((la - lb) / 4 < 64'(depth));
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    function automatic logic [31:0] pick_addr(input logic [31:0] base, input int unsigned depth);
        int unsigned r = $urandom_range(0, 9);
        if (r == 0) return base + 32'(4 * $urandom_range(0, depth - 1)) + 32'($urandom_range(1, 3));
        if (r == 1) return base + 32'(4 * depth) + 32'(4 * $urandom_range(0, 64));
        if (r == 2) return base - 32'(4 * $urandom_range(1, 16));
        return base + 32'(4 * $urandom_range(0, depth - 1));
    endfunction

    // One transaction on instance A; entered and left #1 after a rising edge with A idle.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int          n;
        bit          ok;
        logic [31:0] exp_rd;
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        @(posedge clk); #1;
        // Dropped request and scrambled inputs must not disturb the accepted access.
        a_req = 1'b0; a_we = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
        n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("a_latency", 32'(n), 32'(LAT_A));
        ok     = addr_valid(addr, BASE_A, DEPTH_A);
        exp_rd = (ok && !we) ? mdl_a[int'((addr - BASE_A) >> 2)] : 32'h0;
        check_eq("a_err", 32'(a_err), 32'(!ok));
        check_eq("a_rdata", a_rdata, exp_rd);
        if (!ok) ma_er = sat(ma_er);
        else if (we) begin
            ma_wr = sat(ma_wr);
            mdl_a[int'((addr - BASE_A) >> 2)] = wd;
        end else ma_rd = sat(ma_rd);
        @(posedge clk); #1;
        check_eq("a_ready_pulse", 32'(a_ready), 32'd0);
        check_eq("a_rd_count", 32'(a_rdc), ma_rd);
        check_eq("a_wr_count", 32'(a_wrc), ma_wr);
        check_eq("a_err_count", 32'(a_erc), ma_er);
    endtask

    initial begin
        bit          ok;
        logic        p_we;
        logic [31:0] p_addr, p_wd, exp_rd;
        for (int i = 0; i < int'(DEPTH_A); i++) mdl_a[i] = 32'h0;
        for (int i = 0; i < int'(DEPTH_B); i++) mdl_b[i] = 32'h0;
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(a_ready), 32'd0);
        check_eq("rst_err", 32'(a_err), 32'd0);
        check_eq("rst_rdata", a_rdata, 32'h0);
        check_eq("rst_counts", {a_rdc, a_wrc | a_erc}, 32'h0);
        rst = 1'b0;

        do_txn(1'b1, 32'h40, 32'd14);
        do_txn(1'b0, 32'h40, 32'h0);
        check_eq("word16", u_a.mem_q[16], 32'd14);
        do_txn(1'b1, 32'h44, 32'h0000_0123);
        do_txn(1'b0, 32'h40, 32'h0);
        do_txn(1'b0, 32'h44, 32'h0);
        check_eq("word17", u_a.mem_q[17], 32'h0000_0123);
        do_txn(1'b0, 32'h42, 32'h0);
        do_txn(1'b1, 32'h400, 32'h5A5A_5A5A);
        check_eq("err_count2", 32'(a_erc), 32'd2);
        check_eq("word16_kept", u_a.mem_q[16], 32'd14);

        // Reset while a write sits in WAIT abandons it.
        do_txn(1'b1, 32'h48, 32'hAAAA_5555);
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h48; a_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        a_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ma_rd = 0; ma_wr = 0; ma_er = 0;
        check_eq("abort_ready", 32'(a_ready), 32'd0);
        check_eq("abort_counts", {a_rdc, a_wrc | a_erc}, 32'h0);
        check_eq("word18_kept", u_a.mem_q[18], 32'hAAAA_5555);
        do_txn(1'b0, 32'h48, 32'h0);

        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), pick_addr(BASE_A, DEPTH_A), $urandom);
        end

        // Saturation of the write counter.
        force u_a.wr_count_q = 16'hFFFE;
        #1;
        release u_a.wr_count_q;
        ma_wr = 65534;
        for (int i = 0; i < 3; i++) do_txn(1'b1, 32'(4 * i), $urandom);
        check_eq("wr_sat", 32'(a_wrc), 32'h0000_FFFF);

        // LATENCY=0 instance with mem_req held high: responses on alternate cycles.
        p_we = 1'b1; p_addr = BASE_B; p_wd = $urandom;
        b_req = 1'b1; b_we = p_we; b_addr = p_addr; b_wdata = p_wd;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            ok     = addr_valid(p_addr, BASE_B, DEPTH_B);
            exp_rd = (ok && !p_we) ? mdl_b[int'((p_addr - BASE_B) >> 2)] : 32'h0;
            check_eq("b_ready", 32'(b_ready), 32'd1);
            check_eq("b_err", 32'(b_err), 32'(!ok));
            check_eq("b_rdata", b_rdata, exp_rd);
            if (!ok) mb_er = sat(mb_er);
            else if (p_we) begin
                mb_wr = sat(mb_wr);
                mdl_b[int'((p_addr - BASE_B) >> 2)] = p_wd;
            end else mb_rd = sat(mb_rd);
            b_we = 1'($urandom); b_addr = $urandom; b_wdata = $urandom;
            @(posedge clk); #1;
            check_eq("b_idle", 32'(b_ready), 32'd0);
            p_we   = (k < 4) ? 1'b1 : 1'($urandom);
            p_addr = (k < 4) ? BASE_B + 32'(4 * (k + 1)) : pick_addr(BASE_B, DEPTH_B);
            p_wd   = $urandom;
            b_we = p_we; b_addr = p_addr; b_wdata = p_wd;
            if (k == 23) b_req = 1'b0;
        end
        check_eq("b_rd_count", 32'(b_rdc), mb_rd);
        check_eq("b_wr_count", 32'(b_wrc), mb_wr);
        check_eq("b_err_count", 32'(b_erc), mb_er);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
